// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the detection-event time-stamp queue.
package seq_det_pkg;

    localparam int unsigned TS_WIDTH_DEF  = 16;
    localparam int unsigned DEPTH_DEF     = 8;
    localparam int unsigned CNT_WIDTH_DEF = 16;

    // Increment v, holding at all-ones of a w-bit field (w <= 32).
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int unsigned w
    );
        logic [32:0] max;
        max = (33'd1 << w) - 33'd1;
        if ({1'b0, v} >= max) begin
            return v;
        end
        return v + 32'd1;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; pointers carry an extra MSB
// so full and empty are told apart without a separate flag.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign level_o = wr_ptr_q - rd_ptr_q;
    assign valid_o = (wr_ptr_q != rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A full queue still accepts a write when the head leaves at the same edge.
    assign do_pop  = pop_i && valid_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = data_i;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is left untouched by reset; the pointers define what is live.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/seq_det_event_fifo.sv
// Time-stamps detector pulses and queues them for a valid/ready consumer,
// keeping saturating detection and drop counts plus a sticky overflow flag.
module seq_det_event_fifo
    import seq_det_pkg::*;
#(
    parameter int unsigned TS_WIDTH  = TS_WIDTH_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   detected_i,
    input  logic                   evt_ready_i,
    output logic                   evt_valid_o,
    output logic [TS_WIDTH-1:0]    evt_ts_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic [CNT_WIDTH-1:0]   total_o,
    output logic [CNT_WIDTH-1:0]   drop_o,
    output logic                   overflow_o
);

    logic [TS_WIDTH-1:0]  ts_q, ts_d;
    logic [CNT_WIDTH-1:0] total_q, total_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;
    logic                 ovf_q, ovf_d;
    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 drop;

    assign pop  = evt_valid_o && evt_ready_i;
    assign push = detected_i && (!full || pop);
    assign drop = detected_i && !push;

    sync_fifo_fwft #(
        .WIDTH (TS_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (ts_q),
        .pop_i   (pop),
        .valid_o (evt_valid_o),
        .data_o  (evt_ts_o),
        .level_o (level_o),
        .full_o  (full)
    );

    always_comb begin
        ts_d    = ts_q + 1'b1;
        total_d = total_q;
        drop_d  = drop_q;
        ovf_d   = ovf_q;
        if (detected_i) begin
            total_d = CNT_WIDTH'(sat_inc(32'(total_q), CNT_WIDTH));
        end
        if (drop) begin
            drop_d = CNT_WIDTH'(sat_inc(32'(drop_q), CNT_WIDTH));
            ovf_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts_q    <= '0;
            total_q <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ts_q    <= ts_d;
            total_q <= total_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
        end
    end

    assign total_o    = total_q;
    assign drop_o     = drop_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_seq_det_event_fifo.sv
// Scoreboard bench: default-size instance plus a 4-bit ts / 3-bit count instance.
module tb_seq_det_event_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        det;
    logic        rdy;

    logic        valid;
    logic [15:0] ts;
    logic [3:0]  level;
    logic [15:0] total;
    logic [15:0] dropc;
    logic        ovf;

    logic        valid_s;
    logic [3:0]  ts_s;
    logic [3:0]  level_s;
    logic [2:0]  total_s;
    logic [2:0]  drop_s;
    logic        ovf_s;

    always #5 clk = ~clk;

    seq_det_event_fifo dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .detected_i  (det),
        .evt_ready_i (rdy),
        .evt_valid_o (valid),
        .evt_ts_o    (ts),
        .level_o     (level),
        .total_o     (total),
        .drop_o      (dropc),
        .overflow_o  (ovf)
    );

    seq_det_event_fifo #(
        .TS_WIDTH  (4),
        .DEPTH     (8),
        .CNT_WIDTH (3)
    ) dut_s (
        .clk_i       (clk),
        .rst_i       (rst),
        .detected_i  (det),
        .evt_ready_i (rdy),
        .evt_valid_o (valid_s),
        .evt_ts_o    (ts_s),
        .level_o     (level_s),
        .total_o     (total_s),
        .drop_o      (drop_s),
        .overflow_o  (ovf_s)
    );

    int          checks = 0;
    int          errors = 0;
    int unsigned q[$];
    int unsigned m_ts;
    int unsigned m_total;
    int unsigned m_drop;
    bit          m_ovf;
    bit          m_live = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned sat7(input int unsigned v);
        return (v > 7) ? 7 : v;
    endfunction

    // Drive one edge: compare DUT against the model, then advance the model.
    task automatic tick(input bit r, input bit d, input bit y);
        bit pop;
        bit push;
        rst = r;
        det = d;
        rdy = y;
        #1;
        if (m_live) begin
            chk("valid", 32'(valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("ts", 32'(ts), q[0] & 32'hffff);
                chk("ts_s", 32'(ts_s), q[0] & 32'hf);
            end
            chk("level", 32'(level), q.size());
            chk("total", 32'(total), m_total & 32'hffff);
            chk("drop", 32'(dropc), m_drop & 32'hffff);
            chk("ovf", 32'(ovf), 32'(m_ovf));
            chk("valid_s", 32'(valid_s), 32'(q.size() != 0));
            chk("level_s", 32'(level_s), q.size());
            chk("total_s", 32'(total_s), sat7(m_total));
            chk("drop_s", 32'(drop_s), sat7(m_drop));
            chk("ovf_s", 32'(ovf_s), 32'(m_ovf));
        end
        if (r) begin
            q.delete();
            m_ts    = 0;
            m_total = 0;
            m_drop  = 0;
            m_ovf   = 1'b0;
            m_live  = 1'b1;
        end else begin
            pop  = (q.size() != 0) && y;
            push = d && ((q.size() < 8) || pop);
            if (pop) void'(q.pop_front());
            if (push) q.push_back(m_ts);
            else if (d) begin
                m_drop++;
                m_ovf = 1'b1;
            end
            if (d) m_total++;
            m_ts++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        det = 1'b0;
        rdy = 1'b0;

        // single event at edge 4
        tick(1, 0, 0);
        for (int k = 0; k < 10; k++) tick(0, k == 4, 1);
        chk("single_total", 32'(total), 1);
        chk("single_level", 32'(level), 0);

        // fill to full, then drain in order
        tick(1, 0, 0);
        for (int k = 0; k < 8; k++) tick(0, 1, 0);
        chk("fill_level", 32'(level), 8);
        for (int k = 0; k < 9; k++) tick(0, 0, 1);
        chk("fill_empty", 32'(valid), 0);

        // overflow by two
        tick(1, 0, 0);
        for (int k = 0; k < 10; k++) tick(0, 1, 0);
        chk("ovf_level", 32'(level), 8);
        chk("ovf_drop", 32'(dropc), 2);
        chk("ovf_total", 32'(total), 10);
        chk("ovf_flag", 32'(ovf), 1);
        for (int k = 0; k < 9; k++) tick(0, 0, 1);
        chk("ovf_sticky", 32'(ovf), 1);

        // full with simultaneous push and pop at edge 20
        tick(1, 0, 0);
        for (int k = 0; k < 20; k++) tick(0, k < 8, 0);
        tick(0, 1, 1);
        chk("fpp_level", 32'(level), 8);
        chk("fpp_drop", 32'(dropc), 0);
        for (int k = 0; k < 10; k++) tick(0, 0, 1);

        // timestamp wrap and counter saturation on the small instance
        tick(1, 0, 0);
        for (int k = 0; k < 36; k++) tick(0, (k >= 17) && (k <= 33), 1);
        chk("sat_total_s", 32'(total_s), 7);
        chk("sat_total", 32'(total), 17);

        // reset with five queued entries
        tick(1, 0, 0);
        for (int k = 0; k < 5; k++) tick(0, 1, 0);
        chk("mid_level", 32'(level), 5);
        tick(1, 0, 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_total", 32'(total), 0);
        for (int k = 0; k < 6; k++) tick(0, k == 3, 1);
        tick(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
